// File: rtl/divmod_pow2_seq.sv
// Sequential divide/modulo of a WIDTH-bit operand by 2^k, one shift per clock.
// Build option DIVMOD_SIGNED_EN: two's-complement operand with arithmetic (floor) shift.
module divmod_pow2_seq #(
    parameter int WIDTH = 8,
    parameter int KW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             activate,
    input  logic [WIDTH-1:0] a,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] mod,
    output logic             busy,
    output logic             endop
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [KW-1:0] K_MAX = KW'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [KW-1:0]    keff_q;
    logic [KW-1:0]    cnt_q;

    logic [KW-1:0]    keff_in;
    logic             fill_bit;
    logic [WIDTH-1:0] rem_ins;

    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] kin);
        return (kin > K_MAX) ? K_MAX : kin;
    endfunction

    assign keff_in = clamp_k(k);

`ifdef DIVMOD_SIGNED_EN
    assign fill_bit = quo_q[WIDTH-1];
`else
    assign fill_bit = 1'b0;
`endif

    // The bit leaving the quotient lands at the remainder position equal to the shift index.
    always_comb begin
        rem_ins = rem_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (KW'(i) == cnt_q)
                rem_ins[i] = quo_q[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            quo_q  <= '0;
            rem_q  <= '0;
            keff_q <= '0;
            cnt_q  <= '0;
            div    <= '0;
            mod    <= '0;
            busy   <= 1'b0;
            endop  <= 1'b0;
        end else begin
            endop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (activate) begin
                        quo_q  <= a;
                        rem_q  <= '0;
                        cnt_q  <= '0;
                        keff_q <= keff_in;
                        busy   <= 1'b1;
                        state  <= (keff_in == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    quo_q <= {fill_bit, quo_q[WIDTH-1:1]};
                    rem_q <= rem_ins;
                    cnt_q <= cnt_q + KW'(1);
                    if (cnt_q + KW'(1) == keff_q)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    // Outputs change only here, so partial shift values never appear.
                    div   <= quo_q;
                    mod   <= rem_q;
                    endop <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divmod_pow2_seq.sv
// Bench for divmod_pow2_seq (WIDTH=8): arithmetic reference model with cycle-level
// completion timing, directed literal cases and randomized back-to-back traffic.
module tb_divmod_pow2_seq;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] m;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       activate = 1'b0;
    logic [7:0] a = '0;
    logic [3:0] k = '0;
    logic [7:0] div;
    logic [7:0] mod;
    logic       busy;
    logic       endop;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;

    // reference model state
    logic m_busy = 1'b0;
    logic m_endop = 1'b0;
    logic [7:0] m_div = '0;
    logic [7:0] m_mod = '0;
    int m_left = 0;
    res_t m_pend = '0;

    divmod_pow2_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .activate(activate), .a(a), .k(k),
        .div(div), .mod(mod), .busy(busy), .endop(endop)
    );

    always #5 clk = ~clk;

`ifdef DIVMOD_SIGNED_EN
    localparam logic [7:0] E_K1_D = 8'hDA;
    localparam logic [7:0] E_K3_D = 8'hF6;
    localparam logic [7:0] E_K8_D = 8'hFF;
`else
    localparam logic [7:0] E_K1_D = 8'h5A;
    localparam logic [7:0] E_K3_D = 8'h16;
    localparam logic [7:0] E_K8_D = 8'h00;
`endif

    function automatic int keff_of(input logic [3:0] kv);
        return (kv > 4'd8) ? 8 : int'(kv);
    endfunction

    // Floor division and non-negative remainder by 2^keff.
    function automatic res_t model(input logic [7:0] av, input logic [3:0] kv);
        int p, x, q, r;
        res_t res;
        p = 1 << keff_of(kv);
`ifdef DIVMOD_SIGNED_EN
        x = (av >= 8'd128) ? int'(av) - 256 : int'(av);
`else
        x = int'(av);
`endif
        q = x / p;
        r = x - q * p;
        if (r < 0) begin
            q = q - 1;
            r = r + p;
        end
        res.d = q[7:0];
        res.m = r[7:0];
        return res;
    endfunction

    // Operation accepted when idle completes keff+1 edges later.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_endop <= 1'b0;
            m_div   <= '0;
            m_mod   <= '0;
            m_left  <= 0;
        end else begin
            m_endop <= 1'b0;
            if (m_busy) begin
                if (m_left == 0) begin
                    m_div   <= m_pend.d;
                    m_mod   <= m_pend.m;
                    m_endop <= 1'b1;
                    m_busy  <= 1'b0;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (activate) begin
                m_pend <= model(a, k);
                m_left <= keff_of(k);
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_div", 32'(div), 32'(m_div));
            chk("cyc_mod", 32'(mod), 32'(m_mod));
            chk("cyc_busy", 32'(busy), 32'(m_busy));
            chk("cyc_endop", 32'(endop), 32'(m_endop));
        end
    end

    // Called one posedge before t0 with inputs already driven.
    task automatic wait_done(input string name, input logic [7:0] ed, input logic [7:0] em, input int elat);
        int lat;
        bit seen;
        @(posedge clk);
        #2 activate = 1'b0;
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (endop) seen = 1;
        end
        chk({name, "_latency"}, 32'(lat), 32'(elat));
        chk({name, "_div"}, 32'(div), 32'(ed));
        chk({name, "_mod"}, 32'(mod), 32'(em));
    endtask

    task automatic run_op(input string name, input logic [7:0] av, input logic [3:0] kv,
                          input logic [7:0] ed, input logic [7:0] em, input int elat);
        @(posedge clk);
        #2;
        a = av;
        k = kv;
        activate = 1'b1;
        wait_done(name, ed, em, elat);
    endtask

    initial begin
        int n_end;
        @(posedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_div", 32'(div), 32'h0);
        chk("rst_mod", 32'(mod), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_endop", 32'(endop), 32'h0);

        // model pinned by hand-computed values
        chk("model_k3", 32'(model(8'hB5, 4'd3)), 32'({E_K3_D, 8'h05}));
        chk("model_k12", 32'(model(8'hB5, 4'd12)), 32'({E_K8_D, 8'hB5}));

        run_op("k1", 8'hB5, 4'd1, E_K1_D, 8'h01, 2);
        run_op("k3", 8'hB5, 4'd3, E_K3_D, 8'h05, 4);
        run_op("k0", 8'hB5, 4'd0, 8'hB5, 8'h00, 1);
        run_op("k8", 8'hB5, 4'd8, E_K8_D, 8'hB5, 9);
        run_op("k12", 8'hB5, 4'd12, E_K8_D, 8'hB5, 9);

        // activate during busy is ignored
        @(posedge clk);
        #2 a = 8'hB5; k = 4'd3; activate = 1'b1;
        @(posedge clk);
        #2 activate = 1'b0;
        @(posedge clk);
        #2 a = 8'hFF; k = 4'd0; activate = 1'b1;
        @(posedge clk);
        #2 activate = 1'b0;
        n_end = 0;
        repeat (10) begin
            @(negedge clk);
            if (endop) n_end++;
        end
        chk("busy_ignore_endops", 32'(n_end), 32'd1);
        chk("busy_ignore_div", 32'(div), 32'(E_K3_D));
        chk("busy_ignore_mod", 32'(mod), 32'h05);

        // back-to-back start in the endop cycle
        run_op("b2b_first", 8'hB5, 4'd1, E_K1_D, 8'h01, 2);
        a = 8'h40; k = 4'd2; activate = 1'b1;
        wait_done("b2b_second", 8'h10, 8'h00, 3);

        // reset in the middle of a k=5 operation
        @(posedge clk);
        #2 a = 8'hB5; k = 4'd5; activate = 1'b1;
        @(posedge clk);
        #2 activate = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("abort_div", 32'(div), 32'h0);
        chk("abort_mod", 32'(mod), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_endop", 32'(endop), 32'h0);
        @(posedge clk);
        #2 reset = 1'b0;
        n_end = 0;
        repeat (8) begin
            @(negedge clk);
            if (endop) n_end++;
        end
        chk("abort_no_endop", 32'(n_end), 32'd0);
        run_op("after_abort", 8'h40, 4'd2, 8'h10, 8'h00, 3);

        // randomized traffic; the per-cycle compare does the checking
        repeat (2000) begin
            @(posedge clk);
            #2;
            activate = ($urandom_range(0, 2) == 0);
            a = 8'($urandom);
            k = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #2 activate = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("final_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
